tick_timer_arbiter: RTL and testbench

- Shares one seconds-scale timebase (a prescaled down-counter) among NUM_REQ requesters on the DE2 test platform.
- Each requester asks for a delay of K ticks. The block arbitrates round-robin, grants the timer to one requester, counts K ticks of DIV_COUNT clk50 cycles, then pulses that requester's done.
- Sits between test-sequencing logic (LED/UART/stimulus blocks) and the timebase, replacing per-block free-running dividers.

---
 rtl/tta_pkg.sv | 9 +
 rtl/tick_prescaler.sv | 41 ++++
 rtl/tick_timer_arbiter.sv | 161 ++++++++++++++++
 tb/tb_tick_timer_arbiter.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/tta_pkg.sv
// Shared types and default constants for the tick timer arbiter.
package tta_pkg;

    typedef enum logic [1:0] {IDLE, ARM, RUN, DONE} tta_state_t;

    localparam int unsigned TTA_DIV_COUNT = 50_000_000;
    localparam int unsigned TTA_CNT_W     = 8;

endpackage

// File: rtl/tick_prescaler.sv
// Prescaler for the shared timebase: counts 0..DIV_COUNT-1 while enabled and
// flags the last count as a one-cycle tick.
module tick_prescaler
    import tta_pkg::*;
#(
    parameter int unsigned DIV_COUNT = TTA_DIV_COUNT
) (
    input  logic clk50,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int unsigned CW = (DIV_COUNT > 1) ? $clog2(DIV_COUNT) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV_COUNT - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign tick = en && (cnt_q == LAST);

    // clr wins over en so the owner always starts from a full tick period
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = tick ? '0 : cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk50) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/tick_timer_arbiter.sv
// Round-robin arbiter lending one prescaled timebase to NUM_REQ requesters.
// Define TTA_FIXED_PRIO_EN for fixed priority (lowest index wins).
module tick_timer_arbiter
    import tta_pkg::*;
#(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned DIV_COUNT = TTA_DIV_COUNT,
    parameter int unsigned CNT_W     = TTA_CNT_W
) (
    input  logic                     clk50,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*CNT_W-1:0] req_ticks,
    output logic [NUM_REQ-1:0]       grant,
    output logic [NUM_REQ-1:0]       done,
    output logic                     busy,
    output logic                     tick,
    output logic [CNT_W-1:0]         remaining
);

    localparam int unsigned IDX_W = $clog2(NUM_REQ);

    tta_state_t       state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [CNT_W-1:0] remaining_q, remaining_d;

    logic [CNT_W-1:0]   ticks_arr [NUM_REQ];
    logic [NUM_REQ-1:0] owner_onehot;
    logic [IDX_W-1:0]   sel_idx;
    logic               sel_found;
    logic [IDX_W:0]     cand;
    logic [IDX_W-1:0]   next_ptr;
    logic               presc_clr;
    logic               presc_en;
    logic               presc_tick;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_slice
            assign ticks_arr[gi]    = req_ticks[gi*CNT_W +: CNT_W];
            assign owner_onehot[gi] = (idx_q == IDX_W'(gi));
        end
    endgenerate

    // First pending request at or above the pointer, wrapping past NUM_REQ-1
    always_comb begin
        sel_idx   = '0;
        sel_found = 1'b0;
        cand      = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = {1'b0, ptr_q} + (IDX_W+1)'(i);
            if (cand >= (IDX_W+1)'(NUM_REQ)) begin
                cand = cand - (IDX_W+1)'(NUM_REQ);
            end
            if (!sel_found && req[cand[IDX_W-1:0]]) begin
                sel_found = 1'b1;
                sel_idx   = cand[IDX_W-1:0];
            end
        end
    end

`ifdef TTA_FIXED_PRIO_EN
    assign next_ptr = '0;
`else
    assign next_ptr = (idx_q == IDX_W'(NUM_REQ - 1)) ? '0 : idx_q + IDX_W'(1);
`endif

    tick_prescaler #(
        .DIV_COUNT (DIV_COUNT)
    ) u_prescaler (
        .clk50 (clk50),
        .rst   (rst),
        .clr   (presc_clr),
        .en    (presc_en),
        .tick  (presc_tick)
    );

    always_ff @(posedge clk50) begin
        if (rst) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            ptr_q       <= '0;
            remaining_q <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            ptr_q       <= ptr_d;
            remaining_q <= remaining_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        ptr_d       = ptr_q;
        remaining_d = remaining_q;
        case (state_q)
            IDLE: begin
                if (sel_found) begin
                    idx_d       = sel_idx;
                    remaining_d = ticks_arr[sel_idx];
                    state_d     = (ticks_arr[sel_idx] == '0) ? DONE : ARM;
                end
            end
            ARM: begin
                state_d = RUN;
            end
            RUN: begin
                // A dropped request abandons the timer even on its final tick
                if (!req[idx_q]) begin
                    state_d     = IDLE;
                    remaining_d = '0;
                    ptr_d       = next_ptr;
                end else if (presc_tick && (remaining_q != '0)) begin
                    remaining_d = remaining_q - CNT_W'(1);
                    if (remaining_q == CNT_W'(1)) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d     = IDLE;
                remaining_d = '0;
                ptr_d       = next_ptr;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        grant     = '0;
        done      = '0;
        presc_clr = 1'b0;
        presc_en  = 1'b0;
        case (state_q)
            ARM: begin
                grant     = owner_onehot;
                presc_clr = 1'b1;
            end
            RUN: begin
                grant    = owner_onehot;
                presc_en = 1'b1;
            end
            DONE: begin
                grant = owner_onehot;
                done  = owner_onehot;
            end
            default: begin
                grant = '0;
            end
        endcase
    end

    assign busy      = |grant;
    assign tick      = presc_tick;
    assign remaining = remaining_q;

endmodule

// File: tb/tb_tick_timer_arbiter.sv
// Directed bench for tick_timer_arbiter with DIV_COUNT=4, NUM_REQ=4, CNT_W=8.
module tb_tick_timer_arbiter;

    localparam int unsigned NUM_REQ   = 4;
    localparam int unsigned DIV_COUNT = 4;
    localparam int unsigned CNT_W     = 8;

    logic                     clk50;
    logic                     rst;
    logic [NUM_REQ-1:0]       req;
    logic [NUM_REQ*CNT_W-1:0] req_ticks;
    logic [NUM_REQ-1:0]       grant;
    logic [NUM_REQ-1:0]       done;
    logic                     busy;
    logic                     tick;
    logic [CNT_W-1:0]         remaining;

    int checks;
    int errors;
    int cyc;

    tick_timer_arbiter #(
        .NUM_REQ   (NUM_REQ),
        .DIV_COUNT (DIV_COUNT),
        .CNT_W     (CNT_W)
    ) dut (
        .clk50     (clk50),
        .rst       (rst),
        .req       (req),
        .req_ticks (req_ticks),
        .grant     (grant),
        .done      (done),
        .busy      (busy),
        .tick      (tick),
        .remaining (remaining)
    );

    initial clk50 = 1'b0;
    always #5 clk50 = ~clk50;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk50);
        #1;
        cyc++;
    endtask

    // Leaves the bench just after the last reset edge: cycle 0, DUT in IDLE
    task automatic do_reset();
        rst = 1'b1;
        req = '0;
        next_cycle();
        next_cycle();
        rst = 1'b0;
        cyc = 0;
    endtask

    logic [3:0] exp_fair [5];

    initial begin
        checks    = 0;
        errors    = 0;
        cyc       = 0;
        rst       = 1'b1;
        req       = '0;
        req_ticks = '0;

        // Reset state
        do_reset();
        chk("rst_grant", grant, 4'b0000);
        chk("rst_done", done, 4'b0000);
        chk("rst_busy", busy, 1'b0);
        chk("rst_tick", tick, 1'b0);
        chk("rst_remaining", remaining, 8'd0);

        // Single request, 3 ticks
        req_ticks = {8'd0, 8'd0, 8'd0, 8'd3};
        req       = 4'b0001;
        next_cycle();
        chk("t1_grant_c1", grant, 4'b0001);
        chk("t1_busy_c1", busy, 1'b1);
        chk("t1_rem_c1", remaining, 8'd3);
        req_ticks = {8'd0, 8'd0, 8'd0, 8'd9};
        for (int c = 2; c <= 14; c++) begin
            next_cycle();
            chk($sformatf("t1_tick_c%0d", c), tick, (c == 5 || c == 9 || c == 13));
            chk($sformatf("t1_done_c%0d", c), done, (c == 14) ? 4'b0001 : 4'b0000);
            chk($sformatf("t1_rem_c%0d", c), remaining,
                (c <= 5) ? 8'd3 : (c <= 9) ? 8'd2 : (c <= 13) ? 8'd1 : 8'd0);
        end
        next_cycle();
        chk("t1_busy_c15", busy, 1'b0);
        chk("t1_grant_c15", grant, 4'b0000);
        req = '0;

        // Simultaneous requests 0 and 2, one tick each
        do_reset();
        req_ticks = {8'd1, 8'd1, 8'd1, 8'd1};
        req       = 4'b0101;
        next_cycle();
        chk("t2_grant_c1", grant, 4'b0001);
        while (cyc < 6) next_cycle();
        chk("t2_done_c6", done, 4'b0001);
        next_cycle();
        chk("t2_grant_c7", grant, 4'b0000);
        req = 4'b0100;
        next_cycle();
        chk("t2_grant_c8", grant, 4'b0100);
        chk("t2_rem_c8", remaining, 8'd1);
        while (cyc < 12) next_cycle();
        chk("t2_tick_c12", tick, 1'b1);
        chk("t2_done_c12", done, 4'b0000);
        next_cycle();
        chk("t2_done_c13", done, 4'b0100);
        next_cycle();
        chk("t2_grant_c14", grant, 4'b0000);
        req = '0;

        // Zero ticks on requester 1
        do_reset();
        req_ticks = {8'd7, 8'd7, 8'd0, 8'd7};
        req       = 4'b0010;
        next_cycle();
        chk("t3_done_c1", done, 4'b0010);
        chk("t3_grant_c1", grant, 4'b0010);
        chk("t3_rem_c1", remaining, 8'd0);
        chk("t3_tick_c1", tick, 1'b0);
        next_cycle();
        req = '0;
        for (int c = 2; c <= 4; c++) begin
            chk($sformatf("t3_tick_c%0d", c), tick, 1'b0);
            chk($sformatf("t3_done_c%0d", c), done, 4'b0000);
            next_cycle();
        end

        // Cancel of requester 3 mid-RUN
        do_reset();
        req_ticks = {8'd5, 8'd0, 8'd0, 8'd0};
        req       = 4'b1000;
        next_cycle();
        chk("t4_grant_c1", grant, 4'b1000);
        while (cyc < 7) begin
            next_cycle();
            chk($sformatf("t4_done_c%0d", cyc), done, 4'b0000);
        end
        chk("t4_rem_c7", remaining, 8'd4);
        req = '0;
        next_cycle();
        chk("t4_grant_c8", grant, 4'b0000);
        chk("t4_busy_c8", busy, 1'b0);
        chk("t4_rem_c8", remaining, 8'd0);
        for (int c = 8; c <= 11; c++) begin
            chk($sformatf("t4_done_c%0d", c), done, 4'b0000);
            chk($sformatf("t4_idle_grant_c%0d", c), grant, 4'b0000);
            next_cycle();
        end

        // Reset mid-RUN, after the pointer has moved to 2
        do_reset();
        req_ticks = {8'd0, 8'd5, 8'd0, 8'd5};
        req       = 4'b0010;
        next_cycle();
        chk("t5_done_c1", done, 4'b0010);
        next_cycle();
        req = 4'b0100;
        next_cycle();
        chk("t5_grant_c3", grant, 4'b0100);
        while (cyc < 6) next_cycle();
        chk("t5_busy_c6", busy, 1'b1);
        rst = 1'b1;
        next_cycle();
        chk("t5_grant_c7", grant, 4'b0000);
        chk("t5_done_c7", done, 4'b0000);
        chk("t5_busy_c7", busy, 1'b0);
        chk("t5_tick_c7", tick, 1'b0);
        chk("t5_rem_c7", remaining, 8'd0);
        rst = 1'b0;
        req = 4'b0101;
        next_cycle();
        chk("t5_grant_c8", grant, 4'b0001);
        chk("t5_rem_c8", remaining, 8'd5);
        req = '0;

        // Fairness: all four held high with one tick each
`ifdef TTA_FIXED_PRIO_EN
        exp_fair = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
`else
        exp_fair = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
`endif
        do_reset();
        req_ticks = {8'd1, 8'd1, 8'd1, 8'd1};
        req       = 4'b1111;
        for (int c = 1; c <= 34; c++) begin
            next_cycle();
            if (c % 7 == 1) begin
                chk($sformatf("t6_grant_%0d", c / 7), grant, exp_fair[c / 7]);
            end
            if (c % 7 == 6) begin
                chk($sformatf("t6_done_%0d", c / 7), done, exp_fair[c / 7]);
            end
        end
        req = '0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
